rom_byte_loader: RTL
====================

# rom_byte_loader

Upstream feeder for the 16K x 16-bit program ROM. Accepts a byte stream from the core's data-loader path via a valid/ready handshake and packs byte pairs little-endian into 16-bit words, AVR flash order. Drives the ROM write port with sequential addresses from 0. After the last byte it optionally fills the rest of the ROM with an erased-flash value, so no stale program survives a reload.

## Interface
Parameters:
- ADDR_WIDTH, 14, ROM word-address width; capacity is 2^ADDR_WIDTH words.
- FILL_ENABLE, 1, 1 = fill the remaining words after the stream ends; 0 = stop at the end of the stream.
- FILL_WORD, 16'hFFFF, fill value; its high byte pads an odd trailing byte.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a new load at address 0 and aborts any load in progress.
- in_valid  in  1  byte present on in_data.
- in_ready  out  1  loader accepts a byte this cycle.
- in_data  in  8  stream byte.
- in_last  in  1  qualifies the final byte of the stream; valid only when in_valid is high.
- write_en  out  1  ROM write strobe, one word per cycle.
- write_addr  out  ADDR_WIDTH  ROM word address.
- write_data  out  16  ROM word; [7:0] holds the even byte, [15:8] the odd byte.
- busy  out  1  high in LOAD or FILL.
- done  out  1  high in DONE.
- overflow  out  1  sticky: the stream exceeded capacity; cleared by start or reset.
- word_count  out  ADDR_WIDTH+1  words written from the stream, including a padded word.

## Operation
- States: IDLE, LOAD, FILL, DONE.
- Reset sets state to IDLE. On reset all outputs are 0: in_ready, write_en, write_addr, write_data, busy, done, overflow, word_count.
- start is honoured in every state and takes priority over all other inputs. It sets state to LOAD and clears addr, word_count, overflow and the byte phase. write_en is 0 in the following cycle.
- IDLE: in_ready = 0. Waits for start.
- LOAD: in_ready = 1. A byte is accepted when in_valid & in_ready.
  - Even-phase byte: latched into the low-byte holding register; no write.
  - Odd-phase byte: write {byte, held} to addr, then addr += 1 and word_count += 1.
- in_last accepted in LOAD:
  - If the last byte is in even phase, write {FILL_WORD[15:8], byte}; word_count includes this word.
  - Next state is FILL if FILL_ENABLE = 1 and the ROM is not full; otherwise DONE.
- Capacity: once word_count = 2^ADDR_WIDTH, further bytes are still accepted (in_ready stays 1) but produce no write. overflow is set on the first such byte. addr never wraps to 0.
- FILL: in_ready = 0. Writes FILL_WORD to addr each cycle, incrementing addr. After writing address 2^ADDR_WIDTH-1, state goes to DONE. word_count does not change in FILL.
- DONE: done = 1, in_ready = 0. Holds until start.
- Zero-length streams are unsupported; a load completes only on an accepted in_last.

## Timing
- All outputs are registered.
- A write caused by a byte accepted at edge k has write_en = 1 in the cycle after edge k, together with write_addr and write_data.
- write_en is 0 in every cycle that has no write.
- The edge that accepts in_last also changes state, so in_ready is 0 from the next cycle.
- The first FILL write occurs in the cycle after the last stream write.
- done rises in the cycle after the final write (fill or stream), or in the cycle after the in_last edge if no write is pending.
- Throughput: LOAD sustains 1 byte/cycle with no backpressure. Bubbles on in_valid are allowed and hold the byte phase.
- A start mid-FILL or mid-LOAD stops writes immediately. A partially held byte is discarded.
- A reset in any state gives IDLE and all outputs 0 in the next cycle.

## Test plan
- Even stream: start, then bytes 0C 94 34 00 (last on 00), FILL_ENABLE = 1 -> writes [0] = 16'h940C and [1] = 16'h0034; then 16382 FILL writes of 16'hFFFF at addresses 2..16383; done next cycle; word_count = 2.
- Odd stream: bytes 11 22 33 (last on 33) -> [0] = 16'h2211, [1] = 16'hFF33; word_count = 2.
- Backpressure: the same 4 bytes with in_valid low for 3 cycles between bytes -> identical writes; no write in bubble cycles.
- Overflow: FILL_ENABLE = 0, 32770 bytes -> exactly 16384 writes at addresses 0..16383; overflow = 1; no write to address 0 after the wrap point; done asserts.
- Abort and restart: start, 5 bytes, then start, then bytes AA BB (last) -> the first write after the restart is at address 0 with value 16'hBBAA; the held byte from the aborted load is never written.
- Reset mid-FILL: assert reset during FILL at address 100 -> the next cycle has write_en = 0, state IDLE, all outputs 0; no further writes until start.

Source files
------------

// File: rtl/rom_byte_loader_if.sv
// Byte-stream input and ROM write-port bundle for rom_byte_loader.
// The slave modport is the loader side. The master modport is the feeder/ROM side.
interface rom_byte_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic                  in_last;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [15:0]           write_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, write_en, write_addr, write_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, write_en, write_addr, write_data
  );
endinterface

// File: rtl/rom_byte_loader.sv
// Packs a little-endian byte stream into 16-bit ROM words written from address 0.
// Once the stream ends, it can optionally pad the rest of the ROM with the erased value.
module rom_byte_loader #(
  parameter int          ADDR_WIDTH  = 14,
  parameter bit          FILL_ENABLE = 1'b1,
  parameter logic [15:0] FILL_WORD   = 16'hFFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  rom_byte_loader_if.slave    bus,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_WIDTH:0] word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_held;
  logic                  r_phase;
  logic                  r_in_ready;
  logic                  r_write_en;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic [15:0]           r_write_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;
  logic [ADDR_WIDTH:0]   r_word_count;

  logic        w_accept;
  logic        w_full;
  logic        w_emit;
  logic        w_full_after;
  logic [15:0] w_word;

  assign w_accept     = (r_state == LOAD) && bus.in_valid && r_in_ready;
  assign w_full       = r_word_count[ADDR_WIDTH];
  // A word is produced on every odd byte, and also on an even-phase last byte (padded).
  assign w_emit       = w_accept && !w_full && (r_phase || bus.in_last);
  assign w_full_after = w_emit && (r_word_count == {1'b0, LAST_ADDR});
  assign w_word       = r_phase ? {bus.in_data, r_held} : {FILL_WORD[15:8], bus.in_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_held       <= '0;
      r_phase      <= 1'b0;
      r_in_ready   <= 1'b0;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_write_en <= 1'b0;
      if (start) begin
        r_state      <= LOAD;
        r_addr       <= '0;
        r_word_count <= '0;
        r_overflow   <= 1'b0;
        r_phase      <= 1'b0;
        r_in_ready   <= 1'b1;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_in_ready <= 1'b0;
          end
          LOAD: begin
            if (w_accept) begin
              if (w_emit) begin
                r_write_en   <= 1'b1;
                r_write_addr <= r_addr;
                r_write_data <= w_word;
                r_addr       <= r_addr + 1'b1;
                r_word_count <= r_word_count + 1'b1;
              end
              if (w_full) begin
                r_overflow <= 1'b1;
              end
              if (!w_full && !r_phase) begin
                r_held <= bus.in_data;
              end
              r_phase <= bus.in_last ? 1'b0 : ~r_phase;
              if (bus.in_last) begin
                r_in_ready <= 1'b0;
                if (FILL_ENABLE && !w_full && !w_full_after) begin
                  r_state <= FILL;
                end else begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  // With a write still in flight, done waits one cycle (set from DONE).
                  r_done  <= !w_emit;
                end
              end
            end
          end
          FILL: begin
            r_write_en   <= 1'b1;
            r_write_addr <= r_addr;
            r_write_data <= FILL_WORD;
            r_addr       <= r_addr + 1'b1;
            if (r_addr == LAST_ADDR) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
            end
          end
          DONE: begin
            r_done <= 1'b1;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.write_en   = r_write_en;
  assign bus.write_addr = r_write_addr;
  assign bus.write_data = r_write_data;
  assign busy           = r_busy;
  assign done           = r_done;
  assign overflow       = r_overflow;
  assign word_count     = r_word_count;
endmodule
